// File: rtl/rs232_tx_arb.sv
// Round-robin sequencer sharing one RS232 device transmit path among byte-stream clients.
// Optional RS232_TX_ARB_ID_PREFIX_EN: each granted frame is preceded by header byte 8'hA0 | client.
module rs232_tx_arb #(
  parameter int NUM_CLIENTS = 4,
  parameter int TIMEOUT     = 1024,
  parameter int BAUD_RST    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   cli_valid,
  input  logic [8*NUM_CLIENTS-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]   cli_last,
  output logic [NUM_CLIENTS-1:0]   cli_ready,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic                     abort,
  input  logic                     cfg_wr,
  input  logic                     cfg_baud,
  output logic                     busy,
  output logic                     dev_stb,
  output logic                     dev_we,
  output logic                     dev_addr,
  output logic [7:0]               dev_wdata,
  input  logic [31:0]              dev_rdata,
  input  logic                     dev_ack
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_POLL,
    S_SEND
`ifdef RS232_TX_ARB_ID_PREFIX_EN
    ,
    S_HPOLL,
    S_HSEND
`endif
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   gidx, gidx_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   g_next;
  logic [IW-1:0]   pick;
  logic [IW:0]     sum;
  logic            any;
  logic [TW-1:0]   tcnt;
  logic            cfg_pend;
  logic            pend_baud;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic            timeout_hit;
  logic            unused_rdata;

  assign unused_rdata = ^{dev_rdata[31:4], dev_rdata[2:0]};

  assign g_valid = cli_valid[gidx];
  assign g_last  = cli_last[gidx];
  assign g_data  = cli_data[{gidx, 3'b000} +: 8];
  assign g_next  = (gidx == IW'(NUM_CLIENTS - 1)) ? '0 : gidx + 1'b1;

  // Counter holds the number of earlier idle POLL cycles; the TIMEOUT-th one aborts.
  assign timeout_hit = (TIMEOUT != 0) && (state == S_POLL) && !g_valid && (tcnt == TLIM);

  // First valid client at or above the pointer, wrapping around.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    sum  = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_CLIENTS)) sum = sum - (IW+1)'(NUM_CLIENTS);
      if (!any && cli_valid[sum[IW-1:0]]) begin
        any  = 1'b1;
        pick = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    gidx_n    = gidx;
    ptr_n     = ptr;
    dev_stb   = 1'b0;
    dev_we    = 1'b0;
    dev_addr  = 1'b0;
    dev_wdata = '0;
    cli_ready = '0;
    grant     = '0;
    abort     = 1'b0;
    busy      = (state != S_IDLE) || cfg_pend;
    case (state)
      S_CFG: begin
        dev_stb   = 1'b1;
        dev_we    = 1'b1;
        dev_addr  = 1'b1;
        dev_wdata = {7'b0, pend_baud};
        if (dev_ack) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (cfg_pend) begin
          state_n = S_CFG;
        end else if (any) begin
          gidx_n = pick;
`ifdef RS232_TX_ARB_ID_PREFIX_EN
          state_n = S_HPOLL;
`else
          state_n = S_POLL;
`endif
        end
      end
      S_POLL: begin
        grant[gidx] = 1'b1;
        dev_stb     = 1'b1;
        dev_addr    = 1'b1;
        if (timeout_hit) begin
          abort   = 1'b1;
          ptr_n   = g_next;
          state_n = S_IDLE;
        end else if (dev_ack && dev_rdata[3] && g_valid) begin
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        grant[gidx] = 1'b1;
        dev_stb     = 1'b1;
        dev_we      = 1'b1;
        dev_wdata   = g_data;
        if (dev_ack) begin
          cli_ready[gidx] = 1'b1;
          if (g_last) begin
            ptr_n   = g_next;
            state_n = S_IDLE;
          end else begin
            state_n = S_POLL;
          end
        end
      end
`ifdef RS232_TX_ARB_ID_PREFIX_EN
      S_HPOLL: begin
        grant[gidx] = 1'b1;
        dev_stb     = 1'b1;
        dev_addr    = 1'b1;
        if (dev_ack && dev_rdata[3]) state_n = S_HSEND;
      end
      S_HSEND: begin
        grant[gidx] = 1'b1;
        dev_stb     = 1'b1;
        dev_we      = 1'b1;
        dev_wdata   = 8'hA0 | 8'(gidx);
        if (dev_ack) state_n = S_POLL;
      end
`endif
      default: state_n = S_IDLE;
    endcase
    // Keep every output quiet while reset is held, even though the state sits in CFG.
    if (rst) begin
      dev_stb   = 1'b0;
      dev_we    = 1'b0;
      dev_addr  = 1'b0;
      dev_wdata = '0;
      cli_ready = '0;
      grant     = '0;
      abort     = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CFG;
      gidx      <= '0;
      ptr       <= '0;
      tcnt      <= '0;
      cfg_pend  <= 1'b0;
      pend_baud <= 1'(BAUD_RST);
    end else begin
      state <= state_n;
      gidx  <= gidx_n;
      ptr   <= ptr_n;
      if ((TIMEOUT != 0) && (state == S_POLL) && !g_valid && !timeout_hit)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (cfg_wr) begin
        cfg_pend  <= 1'b1;
        pend_baud <= cfg_baud;
      end else if (state == S_CFG && dev_ack) begin
        cfg_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Scoreboard bench for rs232_tx_arb: expected device writes are queued by stimulus, checked by a monitor.
module tb_rs232_tx_arb;
  localparam int N = 4;
`ifdef RS232_TX_ARB_ID_PREFIX_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   cli_valid;
  logic [8*N-1:0] cli_data;
  logic [N-1:0]   cli_last;
  logic [N-1:0]   cli_ready;
  logic [N-1:0]   grant;
  logic           abort;
  logic           cfg_wr;
  logic           cfg_baud;
  logic           busy;
  logic           dev_stb;
  logic           dev_we;
  logic           dev_addr;
  logic [7:0]     dev_wdata;
  logic [31:0]    dev_rdata;
  logic           dev_ack;
  logic           txbnf;

  rs232_tx_arb #(.NUM_CLIENTS(N), .TIMEOUT(8), .BAUD_RST(1)) dut (
    .clk(clk), .rst(rst), .cli_valid(cli_valid), .cli_data(cli_data), .cli_last(cli_last),
    .cli_ready(cli_ready), .grant(grant), .abort(abort), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
    .busy(busy), .dev_stb(dev_stb), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  assign dev_ack   = dev_stb;
  assign dev_rdata = {28'd0, txbnf, 1'b0, 1'b1, 1'b0};

  int n_vec = 0;
  int n_fail = 0;
  int n_reads = 0;
  int n_writes = 0;
  int n_abort = 0;
  int n_ready[N];

  logic [16:0] sb_q[$];
  logic [16:0] exp_v, act_v;

  logic [8:0]   cmem[N][32];
  int           hd[N];
  int           tl[N];
  logic [N-1:0] hold;
  logic [N-1:0] rdy_s;

  function automatic logic [3:0] oh(input int c);
    return 4'(1 << c);
  endfunction

  task automatic push_exp(input logic [3:0] rdy, input logic [3:0] gnt, input logic a, input logic [7:0] d);
    sb_q.push_back({rdy, gnt, a, d});
  endtask

  task automatic push_byte(input int c, input logic [7:0] d);
    push_exp(oh(c), oh(c), 1'b0, d);
  endtask

  task automatic push_hdr(input int c);
    if (HDR != 0) push_exp(4'b0, oh(c), 1'b0, 8'hA0 | 8'(c));
  endtask

  task automatic push_cfg(input logic b);
    push_exp(4'b0, 4'b0, 1'b1, {7'b0, b});
  endtask

  task automatic enq(input int c, input logic [7:0] d, input logic l);
    cmem[c][tl[c]] = {l, d};
    tl[c]++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit clients_empty();
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(!busy && sb_q.size() == 0 && clients_empty())) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_vec++; n_fail++;
      $display("FAIL %s: not idle after %0d cycles, %0d writes outstanding", name, budget, sb_q.size());
    end
  endtask

  task automatic wait_ready(input string name, input int c, input int target, input int budget);
    int k;
    k = 0;
    while (k < budget && n_ready[c] < target) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_vec++; n_fail++;
      $display("FAIL %s: got %0d ready pulses, expected %0d", name, n_ready[c], target);
    end
  endtask

  // Client model: head byte presented until cli_ready, popped just after the edge.
  initial begin
    cli_valid = '0;
    cli_data  = '0;
    cli_last  = '0;
    for (int i = 0; i < N; i++) hd[i] = 0;
    forever begin
      @(negedge clk);
      rdy_s = cli_ready;
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        if (rdy_s[i] && hd[i] != tl[i]) hd[i]++;
        cli_valid[i]      = (hd[i] != tl[i]) && !hold[i];
        cli_data[8*i +: 8] = cmem[i][hd[i]][7:0];
        cli_last[i]       = cmem[i][hd[i]][8];
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (cli_ready != '0 && !(dev_stb && dev_we && dev_ack)) begin
        n_vec++; n_fail++;
        $display("FAIL ready_no_write: cli_ready=%b with no device write", cli_ready);
      end
      if (dev_stb && dev_ack && dev_we) begin
        n_writes++;
        n_vec++;
        act_v = {cli_ready, grant, dev_addr, dev_wdata};
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL dev_write: unexpected write ready=%b grant=%b addr=%b data=%h",
                   cli_ready, grant, dev_addr, dev_wdata);
        end else begin
          exp_v = sb_q.pop_front();
          if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL dev_write: got ready=%b grant=%b addr=%b data=%h, expected ready=%b grant=%b addr=%b data=%h",
                     act_v[16:13], act_v[12:9], act_v[8], act_v[7:0],
                     exp_v[16:13], exp_v[12:9], exp_v[8], exp_v[7:0]);
          end
        end
      end
      if (dev_stb && !dev_we && dev_addr) n_reads++;
      if (abort) n_abort++;
      for (int i = 0; i < N; i++) if (cli_ready[i]) n_ready[i]++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, a0, q0, q1, q2;
    rst = 1'b1; cfg_wr = 1'b0; cfg_baud = 1'b0; txbnf = 1'b1; hold = '0;
    for (int i = 0; i < N; i++) begin
      tl[i] = 0;
      n_ready[i] = 0;
      for (int j = 0; j < 32; j++) cmem[i][j] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stb", dev_stb, 0);
    check("rst_we", dev_we, 0);
    check("rst_addr", dev_addr, 0);
    check("rst_wdata", dev_wdata, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort, 0);
    check("rst_ready", cli_ready, 0);
    push_cfg(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("cfg_done", sb_q.size(), 0);
    check("idle_stb", dev_stb, 0);
    check("idle_busy", busy, 0);

    // Round robin: clients 0 and 1 both requesting, pointer at 0
    @(posedge clk); #1;
    push_hdr(0); push_byte(0, 8'hA1); push_byte(0, 8'hA2);
    push_hdr(1); push_byte(1, 8'hB1); push_byte(1, 8'hB2);
    push_hdr(0); push_byte(0, 8'hA3); push_byte(0, 8'hA4);
    enq(0, 8'hA1, 1'b0); enq(0, 8'hA2, 1'b1); enq(0, 8'hA3, 1'b0); enq(0, 8'hA4, 1'b1);
    enq(1, 8'hB1, 1'b0); enq(1, 8'hB2, 1'b1);
    wait_idle("rr_idle", 300);
    check("rr_ready0", n_ready[0], 4);
    check("rr_ready1", n_ready[1], 2);

    // Client 2: three-byte frame
    @(posedge clk); #1;
    r0 = n_reads; q0 = n_ready[2];
    push_hdr(2); push_byte(2, 8'h11); push_byte(2, 8'h22); push_byte(2, 8'h33);
    enq(2, 8'h11, 1'b0); enq(2, 8'h22, 1'b0); enq(2, 8'h33, 1'b1);
    wait_idle("c2_idle", 200);
    check("c2_reads", n_reads - r0, 3 + HDR);
    check("c2_ready", n_ready[2] - q0, 3);
    check("c2_grant", grant, 0);

    // Device back-pressure: TXBNF low for 20 cycles after the first byte
    @(posedge clk); #1;
    q0 = n_ready[3];
    push_hdr(3); push_byte(3, 8'hC1); push_byte(3, 8'hC2);
    enq(3, 8'hC1, 1'b0); enq(3, 8'hC2, 1'b1);
    wait_ready("stall_first", 3, q0 + 1, 100);
    @(posedge clk); #1;
    txbnf = 1'b0;
    r0 = n_reads; w0 = n_writes; a0 = n_abort;
    repeat (20) @(posedge clk);
    #1;
    check("stall_reads", n_reads - r0, 20);
    check("stall_writes", n_writes - w0, 0);
    check("stall_abort", n_abort - a0, 0);
    check("stall_grant", grant, 4'b1000);
    txbnf = 1'b1;
    wait_idle("stall_idle", 100);
    check("stall_ready", n_ready[3] - q0, 2);

    // Timeout: client 1 drops valid after first byte, client 2 waiting
    @(posedge clk); #1;
    a0 = n_abort; q1 = n_ready[1]; q2 = n_ready[2];
    push_hdr(1); push_byte(1, 8'hD1);
    push_hdr(2); push_byte(2, 8'hE1);
    push_hdr(1); push_byte(1, 8'hD2);
    enq(1, 8'hD1, 1'b0); enq(1, 8'hD2, 1'b1); enq(2, 8'hE1, 1'b1);
    wait_ready("to_first", 1, q1 + 1, 100);
    @(posedge clk); #1;
    hold[1] = 1'b1;
    r0 = n_reads;
    begin
      int k;
      k = 0;
      while (k < 50 && n_abort == a0) begin
        @(negedge clk); #1;
        k++;
      end
      if (k >= 50) begin
        n_vec++; n_fail++;
        $display("FAIL to_abort: no abort within 50 cycles");
      end
    end
    check("to_polls", n_reads - r0, 8);
    check("to_grant_held", grant, 4'b0010);
    @(posedge clk); #1;
    check("to_grant_clr", grant, 0);
    check("to_abort_pulse", abort, 0);
    @(posedge clk); #1;
    check("to_next_grant", grant, 4'b0100);
    wait_ready("to_c2", 2, q2 + 1, 100);
    @(posedge clk); #1;
    hold[1] = 1'b0;
    wait_idle("to_idle", 200);
    check("to_abort_cnt", n_abort - a0, 1);
    check("to_ready1", n_ready[1] - q1, 2);

    // Config request mid-frame: frame finishes, then control write, then next grant
    @(posedge clk); #1;
    q0 = n_ready[0];
    push_hdr(0); push_byte(0, 8'hF1); push_byte(0, 8'hF2); push_byte(0, 8'hF3);
    push_cfg(1'b1);
    push_hdr(3); push_byte(3, 8'h77);
    enq(0, 8'hF1, 1'b0); enq(0, 8'hF2, 1'b0); enq(0, 8'hF3, 1'b1);
    wait_ready("cfg_first", 0, q0 + 1, 100);
    @(posedge clk); #1;
    cfg_wr = 1'b1; cfg_baud = 1'b1;
    enq(3, 8'h77, 1'b1);
    @(posedge clk); #1;
    cfg_wr = 1'b0; cfg_baud = 1'b0;
    check("cfg_busy", busy, 1);
    check("cfg_grant", grant, 4'b0001);
    wait_idle("cfg_idle", 200);

    // Single-byte frame from client 3
    @(posedge clk); #1;
    q0 = n_ready[3]; w0 = n_writes;
    push_hdr(3); push_byte(3, 8'h5A);
    enq(3, 8'h5A, 1'b1);
    wait_idle("one_idle", 100);
    check("one_ready", n_ready[3] - q0, 1);
    check("one_writes", n_writes - w0, 1 + HDR);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("end_stb", dev_stb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
